// File: rtl/ternary_rand_stream_gen.sv
// Seedable random stimulus source for self-test of the ternary matmul datapath.
// Streams either a D-element fixed-point vector or a DxD ternary matrix over a
// valid/ready interface, tagging every element with its row/column position.
// Ternary draws reject the illegal code 2'b10, so only -1, 0 and +1 appear.
module ternary_rand_stream_gen #(
   parameter int D = 4,
   parameter int FixedPointWidth = 16,
   parameter int LfsrWidth = 32,
   parameter logic [LfsrWidth-1:0] LfsrMask = 32'h80200003
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       mode_i,
   input  logic                       transpose_i,
   input  logic [LfsrWidth-1:0]       seed_i,
   output logic                       busy_o,
   output logic                       elem_valid_o,
   input  logic                       elem_ready_i,
   output logic [FixedPointWidth-1:0] elem_data_o,
   output logic [$clog2(D)-1:0]       elem_row_o,
   output logic [$clog2(D)-1:0]       elem_col_o,
   output logic                       last_o,
   output logic                       done_o
);

   localparam int IdxWidth = $clog2(D);
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(D - 1);

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      HOLD,
      DONE
   } state_t;

   state_t                 state;
   logic [LfsrWidth-1:0]   lfsr;
   logic                   mode;
   logic                   transpose;
   logic [IdxWidth-1:0]    inner;
   logic [IdxWidth-1:0]    outer;

   logic [LfsrWidth-1:0]       nxt;
   logic                       cand_ok;
   logic [FixedPointWidth-1:0] cand_data;
   logic [IdxWidth-1:0]        adv_inner;
   logic [IdxWidth-1:0]        adv_outer;
   logic [IdxWidth-1:0]        use_inner;
   logic [IdxWidth-1:0]        use_outer;
   logic [IdxWidth-1:0]        cand_row;
   logic [IdxWidth-1:0]        cand_col;
   logic                       cand_last;

   // Next Galois LFSR state; this is also the candidate value of any draw.
   always_comb begin
      nxt = (lfsr >> 1) ^ (lfsr[0] ? LfsrMask : '0);
   end

   // Turn the candidate into an element value, rejecting the -2 ternary code.
   always_comb begin
      cand_ok   = 1'b1;
      cand_data = '0;
      if (!mode) begin
         cand_data = nxt[FixedPointWidth-1:0];
      end else begin
         case (nxt[1:0])
            2'b01:   cand_data = FixedPointWidth'(1);
            2'b11:   cand_data = '1;
            2'b10:   cand_ok   = 1'b0;
            default: cand_data = '0;
         endcase
      end
   end

   // A draw in HOLD belongs to the element after the one just handed over, so
   // it is tagged with the advanced counters; a draw in GEN uses them as they are.
   always_comb begin
      adv_inner = inner + 1'b1;
      adv_outer = outer;
      if (mode && inner == LastIdx) begin
         adv_inner = '0;
         adv_outer = outer + 1'b1;
      end
      use_inner = inner;
      use_outer = outer;
      if (state == HOLD) begin
         use_inner = adv_inner;
         use_outer = adv_outer;
      end
   end

   // Map counters onto row/column and flag the final element of the run.
   always_comb begin
      cand_row  = use_inner;
      cand_col  = '0;
      cand_last = (use_inner == LastIdx);
      if (mode) begin
         cand_last = (use_outer == LastIdx) && (use_inner == LastIdx);
         if (transpose) begin
            cand_row = use_inner;
            cand_col = use_outer;
         end else begin
            cand_row = use_outer;
            cand_col = use_inner;
         end
      end
   end

   // Run control: seeding, drawing, holding under backpressure, done pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         lfsr         <= LfsrWidth'(1);
         mode         <= 1'b0;
         transpose    <= 1'b0;
         inner        <= '0;
         outer        <= '0;
         busy_o       <= 1'b0;
         elem_valid_o <= 1'b0;
         elem_data_o  <= '0;
         elem_row_o   <= '0;
         elem_col_o   <= '0;
         last_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  lfsr      <= (seed_i == '0) ? LfsrWidth'(1) : seed_i;
                  mode      <= mode_i;
                  transpose <= transpose_i;
                  inner     <= '0;
                  outer     <= '0;
                  busy_o    <= 1'b1;
                  state     <= GEN;
               end
            end
            GEN: begin
               lfsr <= nxt;
               if (cand_ok) begin
                  elem_data_o  <= cand_data;
                  elem_row_o   <= cand_row;
                  elem_col_o   <= cand_col;
                  last_o       <= cand_last;
                  elem_valid_o <= 1'b1;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (elem_ready_i) begin
                  if (last_o) begin
                     elem_valid_o <= 1'b0;
                     last_o       <= 1'b0;
                     done_o       <= 1'b1;
                     state        <= DONE;
                  end else begin
                     lfsr  <= nxt;
                     inner <= adv_inner;
                     outer <= adv_outer;
                     if (cand_ok) begin
                        elem_data_o <= cand_data;
                        elem_row_o  <= cand_row;
                        elem_col_o  <= cand_col;
                        last_o      <= cand_last;
                     end else begin
                        elem_valid_o <= 1'b0;
                        state        <= GEN;
                     end
                  end
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_rand_stream_gen.sv
// Directed bench for ternary_rand_stream_gen: hand-computed tables for the
// first elements of each run, a reference generator for whole streams, and
// hand-written sequences for backpressure, ignored start and mid-run reset.
module tb_ternary_rand_stream_gen;

   localparam int D = 4;
   localparam logic [31:0] MASK = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic        transpose;
   logic [31:0] seed;
   logic        busy;
   logic        elem_valid;
   logic        elem_ready;
   logic [15:0] elem_data;
   logic [1:0]  elem_row;
   logic [1:0]  elem_col;
   logic        last;
   logic        done;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  row;
      logic [1:0]  col;
      logic        last;
   } elem_t;

   elem_t got[$];
   elem_t stall_obs[$];
   elem_t exp_q[$];
   elem_t vec_table[4];
   elem_t mat_head[3];
   elem_t mat_t_head[3];

   int compared = 0;
   int mismatched = 0;
   int first_valid_k;
   int gap_cycles;
   int model_rejects;
   bit done_seen;

   ternary_rand_stream_gen #(
      .D(4),
      .FixedPointWidth(16),
      .LfsrWidth(32),
      .LfsrMask(32'h80200003)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .start_i(start),
      .mode_i(mode),
      .transpose_i(transpose),
      .seed_i(seed),
      .busy_o(busy),
      .elem_valid_o(elem_valid),
      .elem_ready_i(elem_ready),
      .elem_data_o(elem_data),
      .elem_row_o(elem_row),
      .elem_col_o(elem_col),
      .last_o(last),
      .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic compare_elem(input string tag, input int idx, input elem_t a, input elem_t e);
      check_output($sformatf("%s[%0d].data", tag, idx), 32'(a.data), 32'(e.data));
      check_output($sformatf("%s[%0d].row", tag, idx), 32'(a.row), 32'(e.row));
      check_output($sformatf("%s[%0d].col", tag, idx), 32'(a.col), 32'(e.col));
      check_output($sformatf("%s[%0d].last", tag, idx), 32'(a.last), 32'(e.last));
   endtask

   // Reference stream: walk the LFSR, drop rejected ternary codes, and number
   // elements in raster order of (outer, inner).
   task automatic model_run(input logic m, input logic tr, input logic [31:0] sd);
      logic [31:0] l;
      elem_t e;
      int total;
      int k;
      l = (sd == 32'h0) ? 32'h1 : sd;
      total = m ? D * D : D;
      k = 0;
      model_rejects = 0;
      exp_q.delete();
      while (k < total) begin
         l = (l >> 1) ^ (l[0] ? MASK : 32'h0);
         if (m && l[1:0] == 2'b10) begin
            model_rejects++;
         end else begin
            if (!m) e.data = l[15:0];
            else if (l[1:0] == 2'b11) e.data = 16'hFFFF;
            else e.data = {14'b0, l[1:0]};
            if (!m) begin
               e.row = 2'(k);
               e.col = 2'b00;
            end else if (tr) begin
               e.row = 2'(k % D);
               e.col = 2'(k / D);
            end else begin
               e.row = 2'(k / D);
               e.col = 2'(k % D);
            end
            e.last = (k == total - 1);
            exp_q.push_back(e);
            k++;
         end
      end
   endtask

   task automatic compare_stream(input string tag);
      check_output({tag, ".count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         compare_elem(tag, i, got[i], exp_q[i]);
   endtask

   // Pulse start for one edge with the given run configuration; returns at
   // the falling edge just after start was sampled.
   task automatic apply_stimulus(input logic m, input logic tr, input logic [31:0] sd);
      @(negedge clk);
      start     = 1'b1;
      mode      = m;
      transpose = tr;
      seed      = sd;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consume the stream at falling edges until done, optionally stalling one
   // element or pulsing start while an element is held.
   task automatic collect(input int max_cycles, input int stall_idx, input int stall_len, input int start_idx);
      int stalled;
      bit pulsed;
      elem_t cur;
      stalled = 0;
      pulsed = 0;
      got.delete();
      stall_obs.delete();
      first_valid_k = -1;
      gap_cycles = 0;
      done_seen = 0;
      for (int k = 0; k < max_cycles; k++) begin
         start = 1'b0;
         if (done) begin
            done_seen = 1;
            break;
         end
         if (elem_valid) begin
            cur.data = elem_data;
            cur.row  = elem_row;
            cur.col  = elem_col;
            cur.last = last;
            if (first_valid_k < 0) first_valid_k = k;
            if (!pulsed && got.size() == start_idx) begin
               start     = 1'b1;
               mode      = 1'b0;
               transpose = 1'b1;
               seed      = 32'h5;
               pulsed    = 1;
            end
            if (got.size() == stall_idx && stalled < stall_len) begin
               elem_ready = 1'b0;
               stall_obs.push_back(cur);
               stalled++;
            end else begin
               elem_ready = 1'b1;
               got.push_back(cur);
            end
         end else if (busy) begin
            gap_cycles++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      elem_ready = 1'b1;
      if (!done_seen) check_output("done_timeout", 32'(done_seen), 32'h1);
   endtask

   task automatic check_end_of_run(input string tag);
      check_output({tag, ".busy_in_done"}, 32'(busy), 32'h1);
      @(negedge clk);
      check_output({tag, ".busy_after"}, 32'(busy), 32'h0);
      check_output({tag, ".done_after"}, 32'(done), 32'h0);
   endtask

   initial begin
      vec_table[0] = '{data: 16'h0003, row: 2'd0, col: 2'd0, last: 1'b0};
      vec_table[1] = '{data: 16'h0002, row: 2'd1, col: 2'd0, last: 1'b0};
      vec_table[2] = '{data: 16'h0001, row: 2'd2, col: 2'd0, last: 1'b0};
      vec_table[3] = '{data: 16'h0003, row: 2'd3, col: 2'd0, last: 1'b1};
      mat_head[0]   = '{data: 16'hFFFF, row: 2'd0, col: 2'd0, last: 1'b0};
      mat_head[1]   = '{data: 16'h0001, row: 2'd0, col: 2'd1, last: 1'b0};
      mat_head[2]   = '{data: 16'hFFFF, row: 2'd0, col: 2'd2, last: 1'b0};
      mat_t_head[0] = '{data: 16'hFFFF, row: 2'd0, col: 2'd0, last: 1'b0};
      mat_t_head[1] = '{data: 16'h0001, row: 2'd1, col: 2'd0, last: 1'b0};
      mat_t_head[2] = '{data: 16'hFFFF, row: 2'd2, col: 2'd0, last: 1'b0};

      rst = 1'b1;
      start = 1'b0;
      mode = 1'b0;
      transpose = 1'b0;
      seed = 32'h0;
      elem_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset.valid", 32'(elem_valid), 32'h0);
      check_output("reset.busy", 32'(busy), 32'h0);
      check_output("reset.data", 32'(elem_data), 32'h0);
      check_output("reset.done", 32'(done), 32'h0);
      rst = 1'b0;

      $display("[TB] vector run, seed 1");
      apply_stimulus(1'b0, 1'b0, 32'h1);
      collect(200, -1, 0, -1);
      check_output("vec.first_valid_k", 32'(first_valid_k), 32'h1);
      check_output("vec.len", 32'(got.size()), 32'h4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         compare_elem("vec", i, got[i], vec_table[i]);
      check_end_of_run("vec");

      $display("[TB] vector run, seed 0");
      apply_stimulus(1'b0, 1'b0, 32'h0);
      collect(200, -1, 0, -1);
      check_output("vec0.len", 32'(got.size()), 32'h4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         compare_elem("vec0", i, got[i], vec_table[i]);
      check_end_of_run("vec0");

      $display("[TB] matrix run, seed 1");
      apply_stimulus(1'b1, 1'b0, 32'h1);
      collect(400, -1, 0, -1);
      for (int i = 0; i < 3 && i < got.size(); i++)
         compare_elem("mat_head", i, got[i], mat_head[i]);
      model_run(1'b1, 1'b0, 32'h1);
      compare_stream("mat");
      check_output("mat.gap_cycles", 32'(gap_cycles), 32'(1 + model_rejects));
      check_end_of_run("mat");

      $display("[TB] matrix run, transposed");
      apply_stimulus(1'b1, 1'b1, 32'h1);
      collect(400, -1, 0, -1);
      for (int i = 0; i < 3 && i < got.size(); i++)
         compare_elem("mat_t_head", i, got[i], mat_t_head[i]);
      model_run(1'b1, 1'b1, 32'h1);
      compare_stream("mat_t");
      if (got.size() == 16) begin
         check_output("mat_t.final_row", 32'(got[15].row), 32'h3);
         check_output("mat_t.final_col", 32'(got[15].col), 32'h3);
         check_output("mat_t.final_last", 32'(got[15].last), 32'h1);
      end
      check_end_of_run("mat_t");

      $display("[TB] matrix run with backpressure on element 2");
      apply_stimulus(1'b1, 1'b0, 32'h1);
      collect(400, 2, 5, -1);
      model_run(1'b1, 1'b0, 32'h1);
      check_output("stall.obs_count", 32'(stall_obs.size()), 32'h5);
      for (int i = 0; i < stall_obs.size(); i++)
         compare_elem("stall_hold", i, stall_obs[i], exp_q[2]);
      compare_stream("stall");
      check_end_of_run("stall");

      $display("[TB] vector run with start pulsed while holding");
      apply_stimulus(1'b0, 1'b0, 32'h1);
      collect(200, -1, 0, 1);
      check_output("ign.len", 32'(got.size()), 32'h4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         compare_elem("ign", i, got[i], vec_table[i]);
      check_end_of_run("ign");

      $display("[TB] reset in the middle of a matrix run");
      apply_stimulus(1'b1, 1'b0, 32'h1);
      repeat (5) @(negedge clk);
      check_output("midrun.busy_before", 32'(busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("midrun.valid", 32'(elem_valid), 32'h0);
      check_output("midrun.busy", 32'(busy), 32'h0);
      check_output("midrun.data", 32'(elem_data), 32'h0);
      check_output("midrun.row", 32'(elem_row), 32'h0);
      check_output("midrun.col", 32'(elem_col), 32'h0);
      check_output("midrun.last", 32'(last), 32'h0);
      check_output("midrun.done", 32'(done), 32'h0);
      repeat (3) @(negedge clk);
      check_output("idle.valid", 32'(elem_valid), 32'h0);
      check_output("idle.busy", 32'(busy), 32'h0);
      apply_stimulus(1'b1, 1'b0, 32'h1);
      collect(400, -1, 0, -1);
      check_output("restart.len", 32'(got.size()), 32'd16);
      for (int i = 0; i < 3 && i < got.size(); i++)
         compare_elem("restart", i, got[i], mat_head[i]);
      check_end_of_run("restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
